silife_frame_scheduler: RTL and testbench

Top-level sequencer that time-shares the cell-grid row-select bus between the MAX7219 display driver and the life-generation engine. It issues periodic frame requests to the display driver and starts generation steps in the gaps between frames. It also counts generations and flags display faults. It sits between the grid memory, the display driver (frame/busy handshake) and the generation engine (start/done handshake).

---
 rtl/silife_frame_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_silife_frame_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/silife_frame_scheduler.sv
// silife_frame_scheduler
// Sequencer that time-shares the grid row-select bus between the MAX7219
// display driver and the life-generation engine. It issues a frame request
// every FRAME_TICKS cycles and starts generation steps in the gaps between
// frames. It also counts completed generations, lost frame ticks and display
// start timeouts.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   i_disp_enable         display on/off request
//   i_run, i_step         free-run enable, single-generation request pulse
//   i_speed[3:0]          free-run rate: one generation per (i_speed+1) frames
//   o_disp_enable         registered copy of i_disp_enable
//   o_disp_frame          frame request level to the display driver
//   i_disp_busy           display driver busy
//   i_disp_row_select     row select from the display driver
//   o_gen_start           one-cycle start pulse to the engine
//   i_gen_done            one-cycle completion pulse from the engine
//   i_gen_row_select      row select from the engine
//   o_row_select          muxed row select to grid memory
//   o_owner               0 = display owns the bus, 1 = engine owns the bus
//   o_generation[15:0]    generations completed (wrapping)
//   o_overrun[7:0]        frame ticks lost (saturating)
//   o_disp_fault          sticky frame-request timeout flag
module silife_frame_scheduler #(
  parameter int FRAME_TICKS   = 100000,
  parameter int START_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_disp_enable,
  input  logic        i_run,
  input  logic        i_step,
  input  logic [3:0]  i_speed,
  output logic        o_disp_enable,
  output logic        o_disp_frame,
  input  logic        i_disp_busy,
  input  logic [4:0]  i_disp_row_select,
  output logic        o_gen_start,
  input  logic        i_gen_done,
  input  logic [4:0]  i_gen_row_select,
  output logic [4:0]  o_row_select,
  output logic        o_owner,
  output logic [15:0] o_generation,
  output logic [7:0]  o_overrun,
  output logic        o_disp_fault
);
  localparam int TW  = $clog2(FRAME_TICKS);
  localparam int TOW = $clog2(START_TIMEOUT + 1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(FRAME_TICKS - 1);
  localparam logic [TOW-1:0] TO_LAST   = TOW'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_DISP_REQ, S_DISP_RUN, S_GEN_RUN} state_t;

  state_t         r_state, w_state_nxt;
  logic [TW-1:0]  r_tick_cnt;
  logic [TOW-1:0] r_to_cnt, w_to_nxt;
  logic [3:0]     r_div_cnt;
  logic           r_frame_pending, r_gen_pending;
  logic           r_disp_frame, w_frame_nxt;
  logic           r_owner, w_owner_nxt;
  logic           r_gen_start, w_gen_start_nxt;
  logic           r_disp_enable, r_disp_fault;
  logic [15:0]    r_generation;
  logic [7:0]     r_overrun;

  logic w_frame_tick, w_frame_take, w_gen_take, w_fsm_frame_done;
  logic w_gen_finish, w_timeout, w_frame_done, w_div_fire;

  assign w_frame_tick = (r_tick_cnt == TICK_LAST);
  // A tick while the display is off still paces the divider as a frame.
  assign w_frame_done = w_fsm_frame_done | (w_frame_tick & ~i_disp_enable);
  assign w_div_fire   = i_run & w_frame_done & (r_div_cnt == i_speed);

  always_comb begin
    w_state_nxt      = r_state;
    w_frame_nxt      = r_disp_frame;
    w_owner_nxt      = r_owner;
    w_gen_start_nxt  = 1'b0;
    w_to_nxt         = r_to_cnt;
    w_frame_take     = 1'b0;
    w_gen_take       = 1'b0;
    w_fsm_frame_done = 1'b0;
    w_gen_finish     = 1'b0;
    w_timeout        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_frame_pending && i_disp_enable) begin
          w_state_nxt  = S_DISP_REQ;
          w_frame_nxt  = 1'b1;
          w_owner_nxt  = 1'b0;
          w_to_nxt     = '0;
          w_frame_take = 1'b1;
        end else if (r_gen_pending) begin
          w_state_nxt     = S_GEN_RUN;
          w_owner_nxt     = 1'b1;
          w_gen_start_nxt = 1'b1;
          w_gen_take      = 1'b1;
        end
      end
      S_DISP_REQ: begin
        if (i_disp_busy) begin
          w_state_nxt = S_DISP_RUN;
          w_frame_nxt = 1'b0;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_nxt = S_IDLE;
          w_frame_nxt = 1'b0;
          w_timeout   = 1'b1;
        end else begin
          w_to_nxt = r_to_cnt + 1'b1;
        end
      end
      S_DISP_RUN: begin
        if (!i_disp_busy) begin
          w_state_nxt      = S_IDLE;
          w_fsm_frame_done = 1'b1;
        end
      end
      S_GEN_RUN: begin
        if (i_gen_done) begin
          w_state_nxt  = S_IDLE;
          w_owner_nxt  = 1'b0;
          w_gen_finish = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_tick_cnt      <= '0;
      r_to_cnt        <= '0;
      r_div_cnt       <= '0;
      r_frame_pending <= 1'b0;
      r_gen_pending   <= 1'b0;
      r_disp_frame    <= 1'b0;
      r_owner         <= 1'b0;
      r_gen_start     <= 1'b0;
      r_disp_enable   <= 1'b0;
      r_disp_fault    <= 1'b0;
      r_generation    <= '0;
      r_overrun       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_to_cnt      <= w_to_nxt;
      r_disp_frame  <= w_frame_nxt;
      r_owner       <= w_owner_nxt;
      r_gen_start   <= w_gen_start_nxt;
      r_disp_enable <= i_disp_enable;
      r_tick_cnt    <= w_frame_tick ? '0 : r_tick_cnt + 1'b1;

      // A tick landing on the cycle the pending frame is taken re-arms the
      // flag and is not an overrun.
      if (w_frame_tick) begin
        r_frame_pending <= i_disp_enable;
        if (i_disp_enable && r_frame_pending && !w_frame_take && r_overrun != '1)
          r_overrun <= r_overrun + 1'b1;
      end else if (w_frame_take) begin
        r_frame_pending <= 1'b0;
      end

      // A step arriving as the pending generation is consumed stays pending.
      r_gen_pending <= (r_gen_pending & ~w_gen_take) | i_step | w_div_fire;

      if (!i_run || w_div_fire)
        r_div_cnt <= '0;
      else if (w_frame_done)
        r_div_cnt <= r_div_cnt + 4'd1;

      if (w_gen_finish)
        r_generation <= r_generation + 16'd1;
      if (w_timeout)
        r_disp_fault <= 1'b1;
    end
  end

  assign o_disp_enable = r_disp_enable;
  assign o_disp_frame  = r_disp_frame;
  assign o_gen_start   = r_gen_start;
  assign o_owner       = r_owner;
  assign o_generation  = r_generation;
  assign o_overrun     = r_overrun;
  assign o_disp_fault  = r_disp_fault;
  assign o_row_select  = r_owner ? i_gen_row_select : i_disp_row_select;

endmodule

// File: tb/tb_silife_frame_scheduler.sv
// Directed bench for silife_frame_scheduler with FRAME_TICKS=20 and
// START_TIMEOUT=8. Reactive display and engine models drive the handshakes;
// the main sequence walks through the scenarios with hand-computed results.
module tb_silife_frame_scheduler;
  localparam logic [4:0] DISP_ROW = 5'd3;
  localparam logic [4:0] GEN_ROW  = 5'd28;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_disp_enable = 1'b1;
  logic        i_run = 1'b0;
  logic        i_step = 1'b0;
  logic [3:0]  i_speed = 4'd0;
  logic        o_disp_enable, o_disp_frame, i_disp_busy;
  logic [4:0]  i_disp_row_select, i_gen_row_select, o_row_select;
  logic        o_gen_start, i_gen_done, o_owner, o_disp_fault;
  logic [15:0] o_generation;
  logic [7:0]  o_overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned cyc = 0;

  // model state
  logic disp_respond = 1'b1;
  logic d_act = 1'b0;
  int   d_cnt = 0;
  logic e_act = 1'b0;
  int   e_cnt = 0;
  int   eng_lat = 4;
  int   gen_starts = 0;
  logic exp_owner;
  logic f_prev = 1'b0;
  logic f_mode = 1'b1;
  int   f_len = 0;
  int unsigned t0;

  initial begin
    i_disp_busy = 1'b0;
    i_gen_done  = 1'b0;
    i_disp_row_select = DISP_ROW;
    i_gen_row_select  = GEN_ROW;
  end

  silife_frame_scheduler #(.FRAME_TICKS(20), .START_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_disp_enable(i_disp_enable), .i_run(i_run),
    .i_step(i_step), .i_speed(i_speed), .o_disp_enable(o_disp_enable),
    .o_disp_frame(o_disp_frame), .i_disp_busy(i_disp_busy),
    .i_disp_row_select(i_disp_row_select), .o_gen_start(o_gen_start),
    .i_gen_done(i_gen_done), .i_gen_row_select(i_gen_row_select),
    .o_row_select(o_row_select), .o_owner(o_owner), .o_generation(o_generation),
    .o_overrun(o_overrun), .o_disp_fault(o_disp_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0:       return i_disp_busy;
      1:       return o_disp_frame;
      default: return o_owner;
    endcase
  endfunction

  // Bounded wait; an expired bound shows up as a failed comparison.
  task automatic wait_for(input int sel, input logic lvl, input int limit, input string tag);
    int n = 0;
    while (probe(sel) !== lvl && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    chk(tag, 32'(probe(sel)), 32'(lvl));
  endtask

  task automatic next_cyc();
    @(negedge clk); #1;
  endtask

  // Display/engine models and per-cycle monitors.
  always @(negedge clk) begin
    if (!rst_n) begin
      d_act = 1'b0; d_cnt = 0; i_disp_busy = 1'b0;
      e_act = 1'b0; e_cnt = 0; i_gen_done = 1'b0;
      f_prev = 1'b0; f_len = 0;
    end else begin
      // display: busy rises 2 cycles after the frame and stays 5 cycles
      if (!d_act) begin
        if (o_disp_frame && disp_respond) begin d_act = 1'b1; d_cnt = 0; end
      end else begin
        d_cnt++;
        if (d_cnt == 2) i_disp_busy = 1'b1;
        if (d_cnt == 7) begin i_disp_busy = 1'b0; d_act = 1'b0; end
      end
      // engine: done eng_lat cycles after start
      if (i_gen_done) begin i_gen_done = 1'b0; e_act = 1'b0; end
      if (o_gen_start) begin
        e_act = 1'b1; e_cnt = 0; gen_starts++;
        chk("start_vs_busy", 32'(i_disp_busy), 32'd0);
        chk("start_vs_frame", 32'(o_disp_frame), 32'd0);
      end
      exp_owner = e_act;
      chk("owner", 32'(o_owner), 32'(exp_owner));
      chk("row_sel", 32'(o_row_select), 32'(exp_owner ? GEN_ROW : DISP_ROW));
      if (e_act) begin
        if (e_cnt == eng_lat) i_gen_done = 1'b1;
        e_cnt++;
      end
      // frame request length: 3 with a responding display, 8 on timeout
      if (o_disp_frame) begin
        if (!f_prev) f_mode = disp_respond;
        f_len++;
      end else if (f_prev) begin
        chk("frame_len", 32'(f_len), f_mode ? 32'd3 : 32'd8);
        f_len = 0;
      end
      f_prev = o_disp_frame;
    end
  end

  initial begin
    // reset state
    repeat (3) next_cyc();
    chk("rst_frame", 32'(o_disp_frame), 0);
    chk("rst_start", 32'(o_gen_start), 0);
    chk("rst_owner", 32'(o_owner), 0);
    chk("rst_den", 32'(o_disp_enable), 0);
    chk("rst_gen", 32'(o_generation), 0);
    chk("rst_ovr", 32'(o_overrun), 0);
    chk("rst_fault", 32'(o_disp_fault), 0);
    chk("rst_row", 32'(o_row_select), 32'(DISP_ROW));
    rst_n = 1'b1;
    next_cyc();
    chk("den_follow", 32'(o_disp_enable), 1);

    // periodic frames, one every 20 cycles
    wait_for(1, 1'b1, 40, "s1_first_frame");
    t0 = cyc;
    for (int k = 0; k < 3; k++) begin
      wait_for(1, 1'b0, 10, "s1_frame_lo");
      wait_for(1, 1'b1, 30, "s1_frame_hi");
      chk("s1_period", cyc - t0, 20);
      t0 = cyc;
    end
    chk("s1_gen", 32'(o_generation), 0);

    // free run, speed 2: 3 generations in 9 frames
    wait_for(0, 1'b1, 40, "s2_sync_hi");
    wait_for(0, 1'b0, 10, "s2_sync_lo");
    next_cyc();
    i_run = 1'b1; i_speed = 4'd2;
    for (int k = 0; k < 9; k++) begin
      wait_for(0, 1'b1, 40, "s2_busy_hi");
      wait_for(0, 1'b0, 10, "s2_busy_lo");
    end
    repeat (10) next_cyc();
    chk("s2_gen", 32'(o_generation), 3);
    chk("s2_starts", gen_starts, 3);
    i_run = 1'b0;

    // display never answers: 8-cycle request, sticky fault
    wait_for(1, 1'b0, 20, "s3_idle");
    disp_respond = 1'b0;
    wait_for(1, 1'b1, 40, "s3_frame_hi");
    wait_for(1, 1'b0, 20, "s3_frame_lo");
    chk("s3_fault", 32'(o_disp_fault), 1);
    repeat (30) next_cyc();
    chk("s3_fault_sticky", 32'(o_disp_fault), 1);
    wait_for(1, 1'b0, 20, "s3_idle2");
    disp_respond = 1'b1;

    // engine holds the bus ~50 cycles: one overrun, frame right after done
    wait_for(0, 1'b1, 60, "s4_busy_hi");
    wait_for(0, 1'b0, 10, "s4_busy_lo");
    eng_lat = 48;
    i_step = 1'b1;
    next_cyc();
    i_step = 1'b0;
    wait_for(2, 1'b1, 10, "s4_owner_hi");
    wait_for(2, 1'b0, 80, "s4_owner_lo");
    chk("s4_frame_wait", 32'(o_disp_frame), 0);
    next_cyc();
    chk("s4_frame_now", 32'(o_disp_frame), 1);
    chk("s4_overrun", 32'(o_overrun), 1);
    chk("s4_gen", 32'(o_generation), 4);

    // three steps during one generation merge into one more
    repeat (30) next_cyc();
    wait_for(0, 1'b1, 40, "s5_busy_hi");
    wait_for(0, 1'b0, 10, "s5_busy_lo");
    eng_lat = 10;
    i_step = 1'b1;
    next_cyc();
    i_step = 1'b0;
    wait_for(2, 1'b1, 30, "s5_owner_hi");
    for (int k = 0; k < 3; k++) begin
      i_step = 1'b1;
      next_cyc();
      i_step = 1'b0;
      next_cyc();
    end
    repeat (60) next_cyc();
    chk("s5_gen", 32'(o_generation), 6);
    chk("s5_starts", gen_starts, 6);
    chk("s5_overrun", 32'(o_overrun), 1);

    // reset in DISP_RUN
    wait_for(0, 1'b1, 40, "s6_busy_hi");
    next_cyc();
    rst_n = 1'b0;
    next_cyc();
    chk("s6_frame", 32'(o_disp_frame), 0);
    chk("s6_owner", 32'(o_owner), 0);
    chk("s6_den", 32'(o_disp_enable), 0);
    chk("s6_gen", 32'(o_generation), 0);
    chk("s6_ovr", 32'(o_overrun), 0);
    chk("s6_fault", 32'(o_disp_fault), 0);
    rst_n = 1'b1;
    next_cyc();
    chk("s6_den_back", 32'(o_disp_enable), 1);

    // reset in GEN_RUN
    i_step = 1'b1;
    next_cyc();
    i_step = 1'b0;
    wait_for(2, 1'b1, 40, "s7_owner_hi");
    rst_n = 1'b0;
    next_cyc();
    chk("s7_owner", 32'(o_owner), 0);
    chk("s7_start", 32'(o_gen_start), 0);
    chk("s7_frame", 32'(o_disp_frame), 0);
    chk("s7_gen", 32'(o_generation), 0);
    chk("s7_row", 32'(o_row_select), 32'(DISP_ROW));
    rst_n = 1'b1;
    repeat (40) next_cyc();
    chk("s7_gen_after", 32'(o_generation), 0);
    chk("s7_fault_after", 32'(o_disp_fault), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
